// File: rtl/ifft_butterfly_pipe.sv
// Radix-2 inverse DIT butterfly: a=(y0+y1)/2, b=((y0-y1)/2)*conj(tw); 2-cycle latency, 1 beat/cycle.
// Backpressure: one global advance (!out_valid || out_ready) stalls both stages together; in_ready mirrors it.
module ifft_butterfly_pipe #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] y0_re,
    input  logic [DATA_W-1:0] y0_im,
    input  logic [DATA_W-1:0] y1_re,
    input  logic [DATA_W-1:0] y1_im,
    input  logic [DATA_W-1:0] tw_re,
    input  logic [DATA_W-1:0] tw_im,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_re,
    output logic [DATA_W-1:0] a_im,
    output logic [DATA_W-1:0] b_re,
    output logic [DATA_W-1:0] b_im,
    output logic [TAG_W-1:0]  out_tag
);

    logic adv;

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s_re_q, s_re_d, s_im_q, s_im_d;
    logic [DATA_W-1:0] d_re_q, d_re_d, d_im_q, d_im_d;
    logic [DATA_W-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic [DATA_W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    logic signed [DATA_W-1:0] h0_re, h0_im, h1_re, h1_im;

    assign adv      = !s2_vld_q || out_ready;
    assign in_ready = adv;

    // floor((x+y)/2) = (x>>>1)+(y>>>1)+(x0&y0) and floor((x-y)/2) = (x>>>1)-(y>>>1)-(~x0&y0):
    // bit-identical to halving the DATA_W+1 sum/difference, without ever needing the extra bit.
    always_comb begin
        h0_re = $signed(y0_re) >>> 1;
        h0_im = $signed(y0_im) >>> 1;
        h1_re = $signed(y1_re) >>> 1;
        h1_im = $signed(y1_im) >>> 1;

        s1_vld_d = s1_vld_q;
        s_re_d   = s_re_q;
        s_im_d   = s_im_q;
        d_re_d   = d_re_q;
        d_im_d   = d_im_q;
        tw_re_d  = tw_re_q;
        tw_im_d  = tw_im_q;
        s1_tag_d = s1_tag_q;
        if (adv) begin
            s1_vld_d = in_valid;
            s_re_d   = h0_re + h1_re + DATA_W'(y0_re[0] & y1_re[0]);
            s_im_d   = h0_im + h1_im + DATA_W'(y0_im[0] & y1_im[0]);
            d_re_d   = h0_re - h1_re - DATA_W'(~y0_re[0] & y1_re[0]);
            d_im_d   = h0_im - h1_im - DATA_W'(~y0_im[0] & y1_im[0]);
            tw_re_d  = tw_re;
            tw_im_d  = tw_im;
            s1_tag_d = in_tag;
        end
    end

    // Low DATA_W bits of each full product depend only on the operands' low bits,
    // so a DATA_W-wide multiply-accumulate yields the truncated conj product directly.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        a_re_d    = a_re_q;
        a_im_d    = a_im_q;
        b_re_d    = b_re_q;
        b_im_d    = b_im_q;
        out_tag_d = out_tag_q;
        if (adv) begin
            s2_vld_d  = s1_vld_q;
            a_re_d    = s_re_q;
            a_im_d    = s_im_q;
            b_re_d    = d_re_q * tw_re_q + d_im_q * tw_im_q;
            b_im_d    = d_im_q * tw_re_q - d_re_q * tw_im_q;
            out_tag_d = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s_re_q    <= '0;
            s_im_q    <= '0;
            d_re_q    <= '0;
            d_im_q    <= '0;
            tw_re_q   <= '0;
            tw_im_q   <= '0;
            s1_tag_q  <= '0;
            s2_vld_q  <= 1'b0;
            a_re_q    <= '0;
            a_im_q    <= '0;
            b_re_q    <= '0;
            b_im_q    <= '0;
            out_tag_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s_re_q    <= s_re_d;
            s_im_q    <= s_im_d;
            d_re_q    <= d_re_d;
            d_im_q    <= d_im_d;
            tw_re_q   <= tw_re_d;
            tw_im_q   <= tw_im_d;
            s1_tag_q  <= s1_tag_d;
            s2_vld_q  <= s2_vld_d;
            a_re_q    <= a_re_d;
            a_im_q    <= a_im_d;
            b_re_q    <= b_re_d;
            b_im_q    <= b_im_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign a_re      = a_re_q;
    assign a_im      = a_im_q;
    assign b_re      = b_re_q;
    assign b_im      = b_im_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench for ifft_butterfly_pipe: directed vectors plus randomized beats against an integer reference model.
module tb_ifft_butterfly_pipe;
    localparam int W = 16;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] y0_re = '0, y0_im = '0, y1_re = '0, y1_im = '0, tw_re = '0, tw_im = '0;
    logic [T-1:0] in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic [T-1:0] out_tag;

    ifft_butterfly_pipe #(.DATA_W(W), .TAG_W(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .tw_re(tw_re), .tw_im(tw_im), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a_re, a_im, b_re, b_im;
        logic [T-1:0] tag;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   lat_en = 1'b0;
    int   waits = 0;
    int   stall_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint fl2(input longint x);
        longint r;
        r = ((x % 2) + 2) % 2;
        return (x - r) / 2;
    endfunction

    function automatic exp_t mk(input int ar, ai, br, bi, input logic [T-1:0] tg);
        exp_t e;
        e.a_re = W'(ar); e.a_im = W'(ai); e.b_re = W'(br); e.b_im = W'(bi);
        e.tag = tg; e.acc = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Reference: exact integer math, floor halving, then keep the low W bits of the conj product.
    function automatic exp_t model(input int y0r, y0i, y1r, y1i, twr, twi, input logic [T-1:0] tg);
        longint sr, si, dr, di, br, bi;
        sr = fl2(longint'(y0r) + y1r);
        si = fl2(longint'(y0i) + y1i);
        dr = fl2(longint'(y0r) - y1r);
        di = fl2(longint'(y0i) - y1i);
        br = dr * twr + di * twi;
        bi = di * twr - dr * twi;
        return mk(int'(sr), int'(si), int'(br % 65536), int'(bi % 65536), tg);
    endfunction

    function automatic int rnd();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Called at a negedge; holds the beat until accepted, returns at the following negedge.
    task automatic send(input int y0r, y0i, y1r, y1i, twr, twi, input logic [T-1:0] tg, input exp_t e);
        int k;
        in_valid = 1'b1;
        y0_re = W'(y0r); y0_im = W'(y0i); y1_re = W'(y1r); y1_im = W'(y1i);
        tw_re = W'(twr); tw_im = W'(twi); in_tag = tg;
        k = 0;
        forever begin
            #1;
            if (in_ready) begin
                e.acc = cyc;
                e.lat = lat_en;
                sb.push_back(e);
                break;
            end
            waits++;
            k++;
            if (k > 100) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", k);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [T-1:0] tg);
        int v[6];
        foreach (v[i]) v[i] = rnd();
        send(v[0], v[1], v[2], v[3], v[4], v[5], tg, model(v[0], v[1], v[2], v[3], v[4], v[5], tg));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every completed output handshake.
    initial begin
        bit           stall_prev;
        logic [W-1:0] h_ar, h_ai, h_br, h_bi;
        logic [T-1:0] h_tag;
        exp_t         e;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_a_re", 32'(a_re), 32'(h_ar));
                    chk("stall_a_im", 32'(a_im), 32'(h_ai));
                    chk("stall_b_re", 32'(b_re), 32'(h_br));
                    chk("stall_b_im", 32'(b_im), 32'(h_bi));
                    chk("stall_tag", 32'(out_tag), 32'(h_tag));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_beat: tag=%0d emitted, required no output", out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("a_re", 32'(a_re), 32'(e.a_re));
                        chk("a_im", 32'(a_im), 32'(e.a_im));
                        chk("b_re", 32'(b_re), 32'(e.b_re));
                        chk("b_im", 32'(b_im), 32'(e.b_im));
                        chk("out_tag", 32'(out_tag), 32'(e.tag));
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
                    end
                end
                stall_prev = out_valid && !out_ready;
                if (stall_prev) stall_seen++;
                h_ar = a_re; h_ai = a_im; h_br = b_re; h_bi = b_im; h_tag = out_tag;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_a_re", 32'(a_re), 32'd0);
        chk("rst_a_im", 32'(a_im), 32'd0);
        chk("rst_b_re", 32'(b_re), 32'd0);
        chk("rst_b_im", 32'(b_im), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        lat_en = 1'b1;
        send(97, -13, 103, -27, 0, 1, 4'd5, mk(100, -20, 7, 3, 4'd5));
        send(3, -3, 0, 0, 1, 0, 4'd1, mk(1, -2, 1, -2, 4'd1));
        send(16384, 0, 0, 0, 2, 0, 4'd2, mk(8192, 0, 16384, 0, 4'd2));
        drain();

        // Full-rate stream: no waits allowed, each output exactly 2 cycles after accept.
        waits = 0;
        for (int i = 0; i < 8; i++) send_rand(4'(i));
        drain();
        chk("fullrate_waits", 32'(waits), 32'd0);
        lat_en = 1'b0;

        // Backpressure: 4 beats, then 3+ stalled cycles while a fifth beat waits upstream.
        stall_seen = 0;
        for (int i = 0; i < 4; i++) send_rand(4'(8 + i));
        rdy_mode = 2;
        fork
            send_rand(4'd12);
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("stall_observed", 32'(stall_seen >= 2), 32'd1);

        // Random traffic with random downstream readiness.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) send_rand(4'($urandom_range(0, 15)));
        rdy_mode = 0;
        drain();

        // Reset mid-flight: two beats in flight are discarded.
        @(negedge clk);
        in_valid = 1'b1;
        y0_re = 16'd10; y0_im = 16'd20; y1_re = 16'd30; y1_im = 16'd40;
        tw_re = 16'd1; tw_im = 16'd1; in_tag = 4'd9;
        @(negedge clk);
        in_tag = 4'd10;
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_tag", 32'(out_tag), 32'd0);
        chk("mid_reset_a_re", 32'(a_re), 32'd0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
